mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-requester arbiter that shares the single 256-bit data memory port between the instruction cache (port 0) and the data cache (port 1). It sits between both cache controllers and data memory. Each side keeps its native enable/write/addr/data/ack handshake, so neither cache knows the port is shared. Grant is registered; the arbiter serialises one complete memory transaction at a time.

Parameters:
ADDR_W, 32, address width on all ports
DATA_W, 256, cache-line width on all data ports
RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority, port 1 (dcache) wins

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-low reset
p0_enable_i  in  1  icache memory request, held until p0_ack_o
p0_write_i  in  1  icache write (always 0 in practice; still honoured)
p0_addr_i  in  ADDR_W  icache line address
p0_data_i  in  DATA_W  icache write data
p0_data_o  out  DATA_W  read data to icache
p0_ack_o  out  1  transaction done for port 0
p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_data_o, p1_ack_o: same as port 0, for the dcache
mem_enable_o  out  1  to data memory
mem_write_o  out  1  to data memory
mem_addr_o  out  ADDR_W  to data memory
mem_data_o  out  DATA_W  to data memory
mem_data_i  in  DATA_W  from data memory
mem_ack_i  in  1  one-cycle completion pulse from data memory

Behaviour:
- Clock is clk_i. Reset is rst_i, asynchronous, active-low.
- Reset state: IDLE, grant = none, last_grant = 0.
- Reset values: mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0, p0_ack_o = 0, p1_ack_o = 0.
- States: IDLE, BUSY0, BUSY1, RELEASE.
- IDLE with one request asserted: go to BUSY of that port on the next edge.
- IDLE with both requests asserted and RR_EN = 1: grant the port that is not last_grant.
- IDLE with both requests asserted and RR_EN = 0: grant port 1.
- Latency: no memory signals are driven in the same cycle a request is first seen. The first mem_enable_o is one cycle after the request is sampled in IDLE.
- BUSY0 and BUSY1 drive the memory port combinationally from the granted port: mem_enable_o = pX_enable_i; mem_write_o, mem_addr_o and mem_data_o come from that port.
- Outside BUSY0/BUSY1, all mem_* outputs are 0.
- The ungranted port's request is held pending: no ack, and no memory activity for it.
- p0_data_o and p1_data_o are both mem_data_i, broadcast. Data is only valid when the matching ack is high.
- pX_ack_o = mem_ack_i AND (state == BUSYX). It is a one-cycle pulse.
- A mem_ack_i in IDLE or RELEASE is ignored and never forwarded.
- On mem_ack_i in BUSYX: set last_grant = X and go to RELEASE.
- RELEASE lasts exactly one cycle and then returns to IDLE. It absorbs the requester's registered enable drop, so a stale enable is never re-granted.
- In the IDLE that follows RELEASE, the other port wins if it is requesting (RR_EN = 1).
- Granted port drops enable in BUSY before ack (abort): mem_enable_o follows it to 0 and the state stays in BUSY until mem_ack_i. Requesters must not abort; this rule keeps the memory port from being reassigned mid-transaction.
- Reset mid-transaction: all outputs go to their reset values immediately. The memory must be reset together with the arbiter.
- Back-to-back, same port: the minimum gap between two transactions is 2 idle cycles (RELEASE, then IDLE).

Test Plan:
1. Only p1 requests, read at addr 0x0000_0400. mem_ack_i pulses 10 cycles after mem_enable_o -> mem_enable_o rises 1 cycle after the request; mem_addr_o = 0x400, mem_write_o = 0; p1_ack_o pulses once with p1_data_o = mem_data_i; p0_ack_o stays 0.
2. p0 and p1 request in the same cycle, RR_EN = 1, last_grant = 0 -> p1 served first; p0 served after RELEASE + IDLE; acks arrive in the order p1, then p0.
3. Same as scenario 2 with RR_EN = 0 and p1 re-requesting immediately after its ack -> p1 is granted again and p0 waits (fixed-priority starvation is the documented behaviour).
4. p1 write-back to 0x0000_1A00 with data pattern 0xA5 repeated, while p0 requests -> mem_write_o = 1 and mem_data_o equals the pattern during BUSY1; p0 is not visible on the memory port until after RELEASE.
5. Spurious mem_ack_i in IDLE, and a stale p1_enable_i held 1 cycle past its ack -> no ack is forwarded, and p1 is not re-granted.
6. rst_i driven low in BUSY0 between clock edges -> all outputs are 0 at once, with no clock edge needed; after release, a fresh p0 request is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one data-memory port between the icache (port 0)
// and the dcache (port 1); one complete transaction is serialised at a time.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic [DATA_W-1:0] p0_data_o,
    output logic              p0_ack_o,
    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              p1_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY0   = 2'd1,
        BUSY1   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state_r;
    state_t state_s;
    logic   last_grant_r;
    logic   last_grant_s;

    // State and last-served-port registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            last_grant_r <= last_grant_s;
        end
    end

    // Next-state: grant decision in IDLE, hold until memory ack, one RELEASE cycle
    always_comb begin
        state_s      = state_r;
        last_grant_s = last_grant_r;
        case (state_r)
            IDLE: begin
                if (p0_enable_i && p1_enable_i) begin
                    if (RR_EN && (last_grant_r == 1'b1)) begin
                        state_s = BUSY0;
                    end else begin
                        state_s = BUSY1;
                    end
                end else if (p1_enable_i) begin
                    state_s = BUSY1;
                end else if (p0_enable_i) begin
                    state_s = BUSY0;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY0: begin
                if (mem_ack_i) begin
                    last_grant_s = 1'b0;
                    state_s      = RELEASE;
                end else begin
                    state_s = BUSY0;
                end
            end
            BUSY1: begin
                if (mem_ack_i) begin
                    last_grant_s = 1'b1;
                    state_s      = RELEASE;
                end else begin
                    state_s = BUSY1;
                end
            end
            RELEASE: state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Memory port steering and ack routing; everything idles at zero outside BUSY
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = {ADDR_W{1'b0}};
        mem_data_o   = {DATA_W{1'b0}};
        p0_ack_o     = 1'b0;
        p1_ack_o     = 1'b0;
        case (state_r)
            BUSY0: begin
                mem_enable_o = p0_enable_i;
                mem_write_o  = p0_write_i;
                mem_addr_o   = p0_addr_i;
                mem_data_o   = p0_data_i;
                p0_ack_o     = mem_ack_i;
            end
            BUSY1: begin
                mem_enable_o = p1_enable_i;
                mem_write_o  = p1_write_i;
                mem_addr_o   = p1_addr_i;
                mem_data_o   = p1_data_i;
                p1_ack_o     = mem_ack_i;
            end
            default: mem_enable_o = 1'b0;
        endcase
    end

    // Read data is broadcast; each cache only takes it alongside its own ack
    assign p0_data_o = mem_data_i;
    assign p1_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance (index 0) and a
// fixed-priority instance (index 1), each with its own memory model and scoreboard.
module tb_mem_arbiter;

    localparam int MEM_LAT = 11;

    typedef struct {
        bit           port;
        logic [255:0] data;
    } exp_t;

    logic         clk_i;
    logic         rst_i;
    logic         p0_en [2];
    logic         p0_wr [2];
    logic [31:0]  p0_addr [2];
    logic [255:0] p0_wdata [2];
    logic [255:0] p0_rdata [2];
    logic         p0_ack [2];
    logic         p1_en [2];
    logic         p1_wr [2];
    logic [31:0]  p1_addr [2];
    logic [255:0] p1_wdata [2];
    logic [255:0] p1_rdata [2];
    logic         p1_ack [2];
    logic         mem_en [2];
    logic         mem_wr [2];
    logic [31:0]  mem_addr [2];
    logic [255:0] mem_wdata [2];
    logic [255:0] mem_rdata [2];
    logic         mem_ack [2];
    logic         tack [2];
    logic         spur [2];
    int           cnt [2];

    int   checks = 0;
    int   errors = 0;
    exp_t sb_rr[$];
    exp_t sb_fp[$];

    assign mem_ack[0] = tack[0] | spur[0];
    assign mem_ack[1] = tack[1] | spur[1];

    mem_arbiter #(.ADDR_W(32), .DATA_W(256), .RR_EN(1'b1)) u_rr (
        .clk_i(clk_i), .rst_i(rst_i),
        .p0_enable_i(p0_en[0]), .p0_write_i(p0_wr[0]), .p0_addr_i(p0_addr[0]),
        .p0_data_i(p0_wdata[0]), .p0_data_o(p0_rdata[0]), .p0_ack_o(p0_ack[0]),
        .p1_enable_i(p1_en[0]), .p1_write_i(p1_wr[0]), .p1_addr_i(p1_addr[0]),
        .p1_data_i(p1_wdata[0]), .p1_data_o(p1_rdata[0]), .p1_ack_o(p1_ack[0]),
        .mem_enable_o(mem_en[0]), .mem_write_o(mem_wr[0]), .mem_addr_o(mem_addr[0]),
        .mem_data_o(mem_wdata[0]), .mem_data_i(mem_rdata[0]), .mem_ack_i(mem_ack[0])
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(256), .RR_EN(1'b0)) u_fp (
        .clk_i(clk_i), .rst_i(rst_i),
        .p0_enable_i(p0_en[1]), .p0_write_i(p0_wr[1]), .p0_addr_i(p0_addr[1]),
        .p0_data_i(p0_wdata[1]), .p0_data_o(p0_rdata[1]), .p0_ack_o(p0_ack[1]),
        .p1_enable_i(p1_en[1]), .p1_write_i(p1_wr[1]), .p1_addr_i(p1_addr[1]),
        .p1_data_i(p1_wdata[1]), .p1_data_o(p1_rdata[1]), .p1_ack_o(p1_ack[1]),
        .mem_enable_o(mem_en[1]), .mem_write_o(mem_wr[1]), .mem_addr_o(mem_addr[1]),
        .mem_data_o(mem_wdata[1]), .mem_data_i(mem_rdata[1]), .mem_ack_i(mem_ack[1])
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic push(input int k, input bit port, input logic [31:0] addr);
        exp_t e;
        e.port = port;
        e.data = {8{addr}};
        if (k == 0) sb_rr.push_back(e);
        else        sb_fp.push_back(e);
    endtask

    // Memory model: ack MEM_LAT cycles into a transaction, read data = address replicated
    initial begin
        for (int k = 0; k < 2; k++) begin
            tack[k] = 1'b0; cnt[k] = 0; mem_rdata[k] = '0;
        end
        forever begin
            @(posedge clk_i);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (!rst_i) begin
                    tack[k] = 1'b0; cnt[k] = 0; mem_rdata[k] = '0;
                end else if (tack[k]) begin
                    tack[k] = 1'b0; cnt[k] = 0;
                end else if (mem_en[k]) begin
                    cnt[k]++;
                    if (cnt[k] == MEM_LAT) begin
                        tack[k] = 1'b1;
                        mem_rdata[k] = {8{mem_addr[k]}};
                    end
                end else begin
                    cnt[k] = 0;
                end
            end
        end
    end

    // Scoreboard: every forwarded ack must match the next expected transaction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            for (int k = 0; k < 2; k++) begin
                if (rst_i && (p0_ack[k] || p1_ack[k])) begin
                    chk("sb_one_ack", {p0_ack[k], p1_ack[k]}, (p1_ack[k] ? 2'b01 : 2'b10));
                    if ((k == 0 && sb_rr.size() == 0) || (k == 1 && sb_fp.size() == 0)) begin
                        chk("sb_unexpected_ack", 1'b1, 1'b0);
                    end else begin
                        e = (k == 0) ? sb_rr.pop_front() : sb_fp.pop_front();
                        chk("sb_port", p1_ack[k], e.port);
                        chk("sb_data", p1_ack[k] ? p1_rdata[k] : p0_rdata[k], e.data);
                    end
                end
            end
        end
    end

    task automatic wait_ack(input int k, input string tag, input bit exp_port, output int n);
        bit seen = 1'b0;
        n = 0;
        while (!seen && n < 200) begin
            @(negedge clk_i);
            n++;
            if (p0_ack[k] || p1_ack[k]) seen = 1'b1;
        end
        if (seen) begin
            chk(tag, p1_ack[k], exp_port);
        end else begin
            checks++;
            errors++;
            $error("FAIL %s: observed no ack expected ack within 200 cycles", tag);
        end
    endtask

    task automatic do_reset();
        chk("sb_rr_drained", sb_rr.size(), 0);
        chk("sb_fp_drained", sb_fp.size(), 0);
        sb_rr.delete();
        sb_fp.delete();
        rst_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            p0_en[k] = 1'b0; p0_wr[k] = 1'b0; p0_addr[k] = '0; p0_wdata[k] = '0;
            p1_en[k] = 1'b0; p1_wr[k] = 1'b0; p1_addr[k] = '0; p1_wdata[k] = '0;
            spur[k] = 1'b0;
        end
        @(negedge clk_i);
        for (int k = 0; k < 2; k++) begin
            chk("rst_outputs", {mem_en[k], mem_wr[k], p0_ack[k], p1_ack[k]}, 4'b0000);
            chk("rst_addr", mem_addr[k], 32'h0);
            chk("rst_wdata", mem_wdata[k], 256'h0);
        end
        step();
        step();
        rst_i = 1'b1;
        step();
    endtask

    initial begin
        int n;
        rst_i = 1'b0;
        do_reset();

        // 1: lone p1 read
        p1_addr[0] = 32'h0000_0400; p1_wr[0] = 1'b0; p1_en[0] = 1'b1;
        push(0, 1'b1, 32'h0000_0400);
        @(negedge clk_i);
        chk("t1_no_same_cycle", mem_en[0], 1'b0);
        @(negedge clk_i);
        chk("t1_mem_en", mem_en[0], 1'b1);
        chk("t1_mem_addr", mem_addr[0], 32'h0000_0400);
        chk("t1_mem_wr", mem_wr[0], 1'b0);
        wait_ack(0, "t1_ack_port", 1'b1, n);
        chk("t1_ack_latency", n, 10);
        step();
        p1_en[0] = 1'b0;

        // 2: simultaneous requests, round-robin from last_grant = 0
        do_reset();
        p0_addr[0] = 32'h0000_0100; p1_addr[0] = 32'h0000_0800;
        p0_en[0] = 1'b1; p1_en[0] = 1'b1;
        push(0, 1'b1, 32'h0000_0800);
        push(0, 1'b0, 32'h0000_0100);
        @(negedge clk_i);
        chk("t2_no_same_cycle", mem_en[0], 1'b0);
        wait_ack(0, "t2_first_p1", 1'b1, n);
        step();
        p1_en[0] = 1'b0;
        @(negedge clk_i);
        chk("t2_release_quiet", mem_en[0], 1'b0);
        @(negedge clk_i);
        chk("t2_idle_quiet", mem_en[0], 1'b0);
        @(negedge clk_i);
        chk("t2_p0_en", mem_en[0], 1'b1);
        chk("t2_p0_addr", mem_addr[0], 32'h0000_0100);
        wait_ack(0, "t2_second_p0", 1'b0, n);
        step();
        p0_en[0] = 1'b0;

        // 3: fixed priority, p1 re-requests right away and starves p0
        do_reset();
        p0_addr[1] = 32'h0000_0140; p1_addr[1] = 32'h0000_0880;
        p0_en[1] = 1'b1; p1_en[1] = 1'b1;
        push(1, 1'b1, 32'h0000_0880);
        push(1, 1'b1, 32'h0000_08C0);
        push(1, 1'b0, 32'h0000_0140);
        wait_ack(1, "t3_first_p1", 1'b1, n);
        step();
        p1_en[1] = 1'b0;
        step();
        p1_addr[1] = 32'h0000_08C0; p1_en[1] = 1'b1;
        @(negedge clk_i);
        chk("t3_idle_quiet", mem_en[1], 1'b0);
        @(negedge clk_i);
        chk("t3_p1_again_en", mem_en[1], 1'b1);
        chk("t3_p1_again_addr", mem_addr[1], 32'h0000_08C0);
        wait_ack(1, "t3_second_p1", 1'b1, n);
        step();
        p1_en[1] = 1'b0;
        wait_ack(1, "t3_then_p0", 1'b0, n);
        step();
        p0_en[1] = 1'b0;

        // 4: p1 write-back while p0 waits
        do_reset();
        p1_addr[0] = 32'h0000_1A00; p1_wr[0] = 1'b1; p1_wdata[0] = {32{8'hA5}};
        p0_addr[0] = 32'h0000_2000; p0_en[0] = 1'b1; p1_en[0] = 1'b1;
        push(0, 1'b1, 32'h0000_1A00);
        push(0, 1'b0, 32'h0000_2000);
        @(negedge clk_i);
        chk("t4_no_same_cycle", mem_en[0], 1'b0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            chk("t4_wb_addr", mem_addr[0], 32'h0000_1A00);
            chk("t4_wb_write", mem_wr[0], 1'b1);
            chk("t4_wb_data", mem_wdata[0], {32{8'hA5}});
            if (p1_ack[0] || p0_ack[0]) break;
        end
        chk("t4_wb_acked", p1_ack[0], 1'b1);
        step();
        p1_en[0] = 1'b0; p1_wr[0] = 1'b0;
        @(negedge clk_i);
        chk("t4_release_quiet", mem_en[0], 1'b0);
        @(negedge clk_i);
        chk("t4_idle_quiet", mem_en[0], 1'b0);
        @(negedge clk_i);
        chk("t4_p0_addr", mem_addr[0], 32'h0000_2000);
        chk("t4_p0_write", mem_wr[0], 1'b0);
        wait_ack(0, "t4_p0_ack", 1'b0, n);
        step();
        p0_en[0] = 1'b0;

        // 5: spurious ack in IDLE, then a stale p1 enable through RELEASE
        do_reset();
        spur[0] = 1'b1;
        @(negedge clk_i);
        chk("t5_spur_no_ack", {p0_ack[0], p1_ack[0]}, 2'b00);
        step();
        spur[0] = 1'b0;
        @(negedge clk_i);
        chk("t5_spur_idle", mem_en[0], 1'b0);
        p1_addr[0] = 32'h0000_3000; p1_en[0] = 1'b1;
        push(0, 1'b1, 32'h0000_3000);
        wait_ack(0, "t5_p1_ack", 1'b1, n);
        step();
        step();
        p1_en[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("t5_no_regrant", mem_en[0], 1'b0);
        end

        // 6: asynchronous reset in BUSY0, then a fresh p0 read
        do_reset();
        p0_addr[0] = 32'h0000_4000; p0_wr[0] = 1'b1; p0_wdata[0] = {8{32'hDEAD_BEEF}};
        p0_en[0] = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("t6_busy0_en", mem_en[0], 1'b1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("t6_async_ctrl", {mem_en[0], mem_wr[0], p0_ack[0], p1_ack[0]}, 4'b0000);
        chk("t6_async_addr", mem_addr[0], 32'h0);
        chk("t6_async_data", mem_wdata[0], 256'h0);
        p0_en[0] = 1'b0; p0_wr[0] = 1'b0; p0_wdata[0] = '0;
        step();
        step();
        rst_i = 1'b1;
        step();
        p0_addr[0] = 32'h0000_4400; p0_en[0] = 1'b1;
        push(0, 1'b0, 32'h0000_4400);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("t6_fresh_addr", mem_addr[0], 32'h0000_4400);
        wait_ack(0, "t6_fresh_ack", 1'b0, n);
        step();
        p0_en[0] = 1'b0;

        repeat (4) step();
        chk("end_sb_rr_drained", sb_rr.size(), 0);
        chk("end_sb_fp_drained", sb_fp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
